nes_poll_sequencer: RTL
=======================

# nes_poll_sequencer

Control-side sequencer that owns the shared NES serial bus (latch and clock-pulse lines driven in parallel to the left and right controller ports). It polls both controllers at a fixed frame rate and shifts in all 8 buttons from each controller simultaneously. It publishes registered active-high button vectors plus one-cycle press strobes to the paddle/ball logic. It replaces per-controller hard-wired counter control words with one scheduler serving both requesters.

## Interface
- HALF_PERIOD, 152: cycles per half bit-slot (about 6 us at 25.175 MHz); must be ≥ 4.
- POLL_PERIOD, 419583: cycles between poll ticks (60 Hz).
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  gates frame starts only.
- nes_data_l  in  1  left controller serial data, active-low, asynchronous.
- nes_data_r  in  1  right controller serial data, active-low, asynchronous.
- nes_latch  out  1  shared latch line, registered.
- nes_pulse  out  1  shared clock-pulse line, registered.
- buttons_l  out  8  left buttons, active-high: [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right.
- buttons_r  out  8  right buttons, same bit map.
- pressed_l  out  8  one-cycle rising-edge strobes of buttons_l.
- pressed_r  out  8  one-cycle rising-edge strobes of buttons_r.
- frame_valid  out  1  one-cycle strobe: buttons and pressed updated this cycle.

## Operation
- Poll timer: free-running counter over 0..POLL_PERIOD-1, wraps to 0. poll_tick is asserted while count == POLL_PERIOD-1. The counter runs regardless of FSM state and enable.
- Data inputs pass through a 2-flop synchronizer each. All samples use the synchronized value, inverted to active-high.
- Shift order is A first. Shifted bit index k lands in buttons[7-k].
- FSM states: IDLE, LATCH, WAIT, PULSE_HI, PULSE_LO, DONE. A phase counter of HALF_PERIOD width is reloaded on every state entry. A 3-bit bit index counts samples.
  - IDLE: latch=0, pulse=0. If poll_tick && enable, go to LATCH.
  - LATCH: latch=1 for 2*HALF_PERIOD cycles, then go to WAIT.
  - WAIT: latch=0 for HALF_PERIOD cycles. On the last cycle, sample bit 0 from both controllers into the shift regs, then go to PULSE_HI.
  - PULSE_HI: pulse=1 for HALF_PERIOD cycles, then go to PULSE_LO.
  - PULSE_LO: pulse=0 for HALF_PERIOD cycles. On the last cycle, sample the next bit. After bit 7, go to DONE; otherwise go to PULSE_HI.
  - DONE (1 cycle): buttons <= shift; pressed <= shift & ~buttons(old); frame_valid=1. Then go to IDLE.
- Left and right share the same timing and are never serialized.
- A poll_tick arriving outside IDLE is dropped. No queuing.
- enable deasserted mid-frame: the frame completes normally. Only new starts are blocked.
- pressed and frame_valid are 0 in every cycle except DONE.

## Timing
- Reset values: nes_latch=0, nes_pulse=0, buttons_l/r=0, pressed_l/r=0, frame_valid=0, FSM=IDLE, poll counter=0, shift regs=0, synchronizers=1.
- Reset takes priority in any state: the cycle after reset_n sampled low, all outputs are at reset values.
- First poll_tick occurs at cycle POLL_PERIOD-1 after reset release. nes_latch rises on the following cycle.
- Frame length from latch rise to frame_valid is 17*HALF_PERIOD+1 cycles: LATCH 2H, WAIT H, 7×(H high + H low), DONE 1.
- Exactly 7 pulse highs occur per frame.
- Sample point is the final cycle of each low slot. The 2-cycle synchronizer latency is hidden because HALF_PERIOD ≥ 4.
- buttons update exactly in the frame_valid cycle and hold until the next DONE.
- If POLL_PERIOD ≤ 17*HALF_PERIOD+1, every other tick is dropped. This is legal and not an error.

## Test plan
Use HALF_PERIOD=4 and POLL_PERIOD=100 unless noted.

- **Reset/start:** release reset. All outputs stay 0 through cycle 99. nes_latch is high for cycles 100-107. 7 pulses follow, each 4 cycles high and 4 low. frame_valid pulses at cycle 168 after release.
- **Decode:** the left model drives low on bit slots 0 (A) and 4 (Up); the right model is idle high. Required: buttons_l=8'h88, buttons_r=8'h00, pressed_l=8'h88 for one cycle with frame_valid, pressed_r=0.
- **Hold/release:** the same stimulus in the next frame gives buttons_l=8'h88 and pressed_l=0. A third frame with Down only gives buttons_l=8'h04 and pressed_l=8'h04.
- **Enable:** hold enable=0 over two ticks; no latch and no frame_valid. Drop enable during PULSE_HI of bit 3; the frame completes, frame_valid fires, and there is no further latch.
- **Reset mid-frame:** assert reset_n=0 for 1 cycle during PULSE_HI of bit 5, with prior buttons_l=8'h88. Next cycle: nes_pulse=0, buttons_l=0. Next latch rises 100 cycles after release.
- **Tick overlap:** POLL_PERIOD=50 (frame is 69 cycles). The tick at cycle 99 is dropped. Latches start at cycles 50 and 150 only.

Source files
------------

// File: rtl/nes_poll_sequencer.sv
// Purpose : polls the left and right NES controllers over one shared latch/pulse bus
//           and publishes the debounced-by-frame button state to the game logic.
// Latency : buttons/pressed/frame_valid update 17*HALF_PERIOD+1 cycles after nes_latch rises.
// Backpressure: none. Results are one-cycle strobes and the consumer must take them when they appear.
//
// Ports:
//   clk, reset_n          system clock and synchronous active-low reset
//   enable                gates the start of a new poll frame only
//   nes_data_l/_r         asynchronous, active-low serial data from each controller
//   nes_latch, nes_pulse  shared bus control lines, registered
//   buttons_l/_r          held button state, active-high, [7]A [6]B [5]Sel [4]Start [3]Up [2]Dn [1]L [0]R
//   pressed_l/_r          rising-edge strobes, valid only with frame_valid
//   frame_valid           one-cycle strobe marking the cycle in which buttons/pressed update
module nes_poll_sequencer #(
  parameter int HALF_PERIOD = 152,
  parameter int POLL_PERIOD = 419583
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       nes_data_l,
  input  logic       nes_data_r,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons_l,
  output logic [7:0] buttons_r,
  output logic [7:0] pressed_l,
  output logic [7:0] pressed_r,
  output logic       frame_valid
);

  localparam int POLL_W = $clog2(POLL_PERIOD + 1);
  // The phase counter must hold the longest slot, which is the 2*HALF_PERIOD latch.
  localparam int PH_W   = $clog2(2 * HALF_PERIOD);

  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_LATCH  = PH_W'(2 * HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_WAIT,
    S_PULSE_HI,
    S_PULSE_LO,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Free-running frame-rate timer; never stalled by the FSM or enable.
  // ---------------------------------------------------------------------------
  logic [POLL_W-1:0] poll_cnt;
  logic              poll_tick;

  assign poll_tick = (poll_cnt == POLL_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (poll_tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers. They reset to 1 (idle line level) so that no
  // phantom press is seen right after reset.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_l;
  logic [1:0] sync_r;
  logic       bit_l;
  logic       bit_r;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_l <= 2'b11;
      sync_r <= 2'b11;
    end else begin
      sync_l <= {sync_l[0], nes_data_l};
      sync_r <= {sync_r[0], nes_data_r};
    end
  end

  assign bit_l = ~sync_l[1];
  assign bit_r = ~sync_r[1];

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t          state;
  logic [PH_W-1:0] phase;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_l;
  logic [7:0]      shift_r;
  logic [7:0]      shift_l_nxt;
  logic [7:0]      shift_r_nxt;
  logic            phase_last;

  // A is shifted in first, so after eight shifts bit 0 sits in [7].
  assign shift_l_nxt = {shift_l[6:0], bit_l};
  assign shift_r_nxt = {shift_r[6:0], bit_r};
  assign phase_last  = (phase == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      phase       <= '0;
      bit_idx     <= '0;
      shift_l     <= '0;
      shift_r     <= '0;
      nes_latch   <= 1'b0;
      nes_pulse   <= 1'b0;
      buttons_l   <= '0;
      buttons_r   <= '0;
      pressed_l   <= '0;
      pressed_r   <= '0;
      frame_valid <= 1'b0;
    end else begin
      // Strobes live for exactly one cycle; only the transition into DONE raises them.
      pressed_l   <= '0;
      pressed_r   <= '0;
      frame_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          // Ticks arriving in any other state are simply lost.
          if (poll_tick && enable) begin
            state     <= S_LATCH;
            phase     <= PH_LATCH;
            nes_latch <= 1'b1;
          end
        end

        S_LATCH: begin
          if (phase_last) begin
            state     <= S_WAIT;
            phase     <= PH_HALF;
            nes_latch <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end

        S_WAIT: begin
          if (phase_last) begin
            // Bit 0 (A) is presented by the controller as soon as it is latched.
            shift_l   <= shift_l_nxt;
            shift_r   <= shift_r_nxt;
            bit_idx   <= 3'd1;
            state     <= S_PULSE_HI;
            phase     <= PH_HALF;
            nes_pulse <= 1'b1;
          end else begin
            phase <= phase - 1'b1;
          end
        end

        S_PULSE_HI: begin
          if (phase_last) begin
            state     <= S_PULSE_LO;
            phase     <= PH_HALF;
            nes_pulse <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end

        S_PULSE_LO: begin
          if (phase_last) begin
            shift_l <= shift_l_nxt;
            shift_r <= shift_r_nxt;
            if (bit_idx == 3'd7) begin
              // Publish on entry to DONE so the update coincides with frame_valid.
              state       <= S_DONE;
              buttons_l   <= shift_l_nxt;
              buttons_r   <= shift_r_nxt;
              pressed_l   <= shift_l_nxt & ~buttons_l;
              pressed_r   <= shift_r_nxt & ~buttons_r;
              frame_valid <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              state     <= S_PULSE_HI;
              phase     <= PH_HALF;
              nes_pulse <= 1'b1;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
